// File: rtl/OoO_pkg.sv
// Shared frontend types: the fetch-queue entry and the default reset PC.
package OoO_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetched {pc, inst} entries; flush empties it.
module fetch_queue
  import OoO_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   push_pc_i,
  input  logic [31:0]   push_inst_i,
  input  logic          pop_i,
  output logic [31:0]   head_pc_o,
  output logic [31:0]   head_inst_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop      = pop_i && (count_q != '0);
  assign count_o     = count_q;
  assign head_pc_o   = mem_q[rd_q].pc;
  assign head_inst_o = mem_q[rd_q].inst;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_q] <= '{pc: push_pc_i, inst: push_inst_i};
  end

  // The credit check upstream must keep a slot free for every response.
  assert property (@(posedge clock) disable iff (reset)
    !(push_i && !do_pop && !flush_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, issues one ICU request at a time, queues returned words for decode.
module ifu_fetch
  import OoO_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_frontend,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_addr,
  output logic        ifu2icu_valid,
  input  logic        icu2ifu_ready,
  input  logic        icu2ifu_valid,
  output logic        ifu2icu_ready,
  input  logic [31:0] ic_val,
  input  logic [31:0] ic_addr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] fq_count;
  logic          issue, resp_fire, push, pop;

  assign ifu2icu_ready = 1'b1;
  assign fetch_addr    = reset ? word_align(RESET_PC) : pc_q;
  // Drop blocks issue so a stale response can never be mistaken for the redirected one.
  assign ifu2icu_valid = !reset && !flush_frontend && !outstanding_q && !drop_q
                         && (fq_count < CW'(FQ_DEPTH));
  assign issue     = ifu2icu_valid && icu2ifu_ready;
  assign resp_fire = icu2ifu_valid && ifu2icu_ready;
  assign push      = resp_fire && outstanding_q && !drop_q && !flush_frontend;
  assign id_valid  = !reset && (fq_count != '0);
  assign pop       = id_valid && id_ready;

  // NOTE: every next-state signal gets a default first, so no latch is inferred.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (flush_frontend) begin
      pc_d          = word_align(redirect_pc);
      outstanding_d = 1'b0;
      drop_d        = (outstanding_q || drop_q) && !resp_fire;
    end else begin
      if (resp_fire) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
      if (issue) begin
        outstanding_d = 1'b1;
        pc_d          = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= word_align(RESET_PC);
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush_frontend),
    .push_i      (push),
    .push_pc_i   (ic_addr),
    .push_inst_i (ic_val),
    .pop_i       (pop),
    .head_pc_o   (id_pc),
    .head_inst_o (id_inst),
    .count_o     (fq_count)
  );

  assert property (@(posedge clock) disable iff (reset)
    icu2ifu_valid |-> (outstanding_q || drop_q));

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: ICU responder, stream reference model and scoreboard monitor.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          FQ_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, flush_frontend;
  logic [31:0] redirect_pc, fetch_addr, ic_val, ic_addr, id_inst, id_pc;
  logic        ifu2icu_valid, icu2ifu_ready, icu2ifu_valid, ifu2icu_ready;
  logic        id_valid, id_ready;

  always #5 clock = ~clock;

  ifu_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush_frontend (flush_frontend),
    .redirect_pc    (redirect_pc),
    .fetch_addr     (fetch_addr),
    .ifu2icu_valid  (ifu2icu_valid),
    .icu2ifu_ready  (icu2ifu_ready),
    .icu2ifu_valid  (icu2ifu_valid),
    .ifu2icu_ready  (ifu2icu_ready),
    .ic_val         (ic_val),
    .ic_addr        (ic_addr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  exp_t        exp_q[$];     // words decode should see, in order
  logic [31:0] model_pc;     // next address the fetch stream should request
  int          occ;          // model fetch-queue occupancy
  bit          icu_busy, icu_live;
  logic [31:0] icu_addr;
  int          icu_wait, icu_lat_min, icu_lat_max, icu_ready_pct;
  bit          issue_seen;
  logic [31:0] addr_seen;
  int          n_checks, n_pass;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // ICU model: accepts requests, answers after a random latency with a word derived from the address.
  initial begin
    forever begin
      @(negedge clock);
      issue_seen = ifu2icu_valid && icu2ifu_ready;
      addr_seen  = fetch_addr;
      @(posedge clock);
      #1;
      if (reset) begin
        icu_busy      = 1'b0;
        icu2ifu_valid = 1'b0;
      end else begin
        if (icu2ifu_valid) begin
          icu2ifu_valid = 1'b0;
          icu_busy      = 1'b0;
          ic_val        = $urandom;
          ic_addr       = $urandom;
        end
        if (issue_seen) begin
          check("fetch_addr", addr_seen, model_pc);
          exp_q.push_back('{pc: model_pc, inst: inst_of(model_pc)});
          model_pc = model_pc + 32'd4;
          icu_busy = 1'b1;
          icu_live = 1'b1;
          icu_addr = addr_seen;
          icu_wait = $urandom_range(icu_lat_max, icu_lat_min) - 1;
        end
        if (icu_busy) begin
          if (icu_wait == 0) begin
            icu2ifu_valid = 1'b1;
            ic_addr       = icu_addr;
            ic_val        = inst_of(icu_addr);
          end else begin
            icu_wait--;
          end
        end
      end
      icu2ifu_ready = ($urandom_range(99) < icu_ready_pct);
    end
  end

  // Monitor: per-cycle handshake checks and scoreboard pops on every decode transfer.
  initial begin
    forever begin
      @(negedge clock);
      check("ifu2icu_ready", {31'd0, ifu2icu_ready}, 32'd1);
      check("ifu2icu_valid", {31'd0, ifu2icu_valid},
            {31'd0, !reset && !flush_frontend && !icu_busy && occ < FQ_DEPTH});
      check("id_valid", {31'd0, id_valid}, {31'd0, !reset && occ != 0});
      if (reset) check("reset_fetch_addr", fetch_addr, RESET_PC);
      if (!reset && !flush_frontend && occ != 0 && id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL id_pop: decode received pc %h with nothing expected", id_pc);
        end else begin
          check("id_pc", id_pc, exp_q[0].pc);
          check("id_inst", id_inst, exp_q[0].inst);
          void'(exp_q.pop_front());
        end
      end
      if (reset || flush_frontend) occ = 0;
      else occ = occ + ((icu2ifu_valid && icu_live) ? 1 : 0) - ((occ != 0 && id_ready) ? 1 : 0);
    end
  end

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    exp_q.delete();
    model_pc = RESET_PC;
    icu_live = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] addr);
    flush_frontend = 1'b1;
    redirect_pc    = addr;
    exp_q.delete();
    model_pc       = addr & ~32'h3;
    icu_live       = 1'b0;
    tick();
    flush_frontend = 1'b0;
    redirect_pc    = $urandom;
  endtask

  task automatic wait_occ(input int target, input int budget);
    for (int i = 0; i < budget && occ != target; i++) tick();
    if (occ != target) begin
      n_checks++;
      $display("FAIL wait_occ: occupancy %0d, wanted %0d", occ, target);
    end
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !icu_busy; i++) tick();
    if (!icu_busy) begin
      n_checks++;
      $display("FAIL wait_busy: no request issued within %0d cycles", budget);
    end
  endtask

  initial begin
    n_checks = 0;  n_pass = 0;  occ = 0;
    reset = 1'b1;  flush_frontend = 1'b0;  redirect_pc = '0;  id_ready = 1'b1;
    icu2ifu_valid = 1'b0;  icu2ifu_ready = 1'b1;  ic_val = '0;  ic_addr = '0;
    icu_busy = 1'b0;  icu_live = 1'b0;  icu_wait = 0;  icu_addr = '0;
    icu_lat_min = 1;  icu_lat_max = 1;  icu_ready_pct = 100;
    model_pc = RESET_PC;

    do_reset(3);
    repeat (20) tick();                 // streaming, ideal 1-cycle ICU
    id_ready = 1'b0;
    repeat (20) tick();                 // fills to four entries and stalls
    id_ready = 1'b1;
    repeat (20) tick();

    id_ready = 1'b0;
    wait_occ(3, 40);
    flush_to(32'h8000_0103);            // redirect with a partially filled queue
    id_ready = 1'b1;
    repeat (12) tick();

    icu_lat_min = 3;  icu_lat_max = 3;
    wait_busy(20);
    flush_to(32'h9000_0040);            // stale response still in flight
    repeat (20) tick();

    icu_lat_min = 1;  icu_lat_max = 1;
    flush_to(32'hFFFF_FFFE);            // PC wraps past the top of the address space
    repeat (10) tick();

    icu_lat_min = 2;  icu_lat_max = 2;
    repeat (5) tick();
    do_reset(2);                        // reset mid-stream
    repeat (10) tick();

    icu_lat_min = 1;  icu_lat_max = 4;  icu_ready_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      int r;
      id_ready = ($urandom_range(9) < 7);
      r = $urandom_range(399);
      if (r == 0)      do_reset($urandom_range(2, 1));
      else if (r < 12) flush_to($urandom);
      else             tick();
    end

    icu_lat_min = 1;  icu_lat_max = 1;  icu_ready_pct = 100;  id_ready = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
